// File: rtl/mem_access_unit.sv
// Memory-access stage: turns decoded store/load operations into one data-memory
// transaction (request/grant, then read-valid for loads), positions store bytes
// on little-endian lanes, and formats load results for register writeback.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  mem_wen_pick,
    input  logic        mem_read,
    input  logic [15:0] reg_write_src,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    output logic [31:0] load_data,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_R, S_DONE} state_t;

    typedef enum logic [3:0] {
        OP_NONE, OP_SW, OP_SH, OP_SB, OP_SWL, OP_SWR,
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_LWL, OP_LWR
    } op_t;

    // Last counter value before a wait in REQ or WAIT_R is abandoned.
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_next_state;
    op_t         r_op, w_op;
    logic [1:0]  r_a;
    logic [31:0] r_rt;
    logic [29:0] r_word;
    logic [3:0]  r_wen, w_wen;
    logic [31:0] r_wdata, w_wdata;
    logic [15:0] r_cnt;
    logic [31:0] r_load_data, w_fmt;
    logic        r_addr_err, r_bus_err;
    logic        w_misaligned, w_timeout, w_is_store;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_unused;

    // Writeback one-hot bits that do not select a load kind are don't-care.
    assign w_unused = ^{reg_write_src[6:0], reg_write_src[15:14]};

    // Decode the incoming operation; stores beat loads, sw>sh>sb>swl>swr.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_op = OP_NONE;
        if      (mem_wen_pick[0]) w_op = OP_SW;
        else if (mem_wen_pick[1]) w_op = OP_SH;
        else if (mem_wen_pick[2]) w_op = OP_SB;
        else if (mem_wen_pick[3]) w_op = OP_SWL;
        else if (mem_wen_pick[4]) w_op = OP_SWR;
        else if (mem_read) begin
            if      (reg_write_src[13]) w_op = OP_LW;
            else if (reg_write_src[9])  w_op = OP_LH;
            else if (reg_write_src[10]) w_op = OP_LHU;
            else if (reg_write_src[7])  w_op = OP_LB;
            else if (reg_write_src[8])  w_op = OP_LBU;
            else if (reg_write_src[11]) w_op = OP_LWL;
            else if (reg_write_src[12]) w_op = OP_LWR;
            else                        w_op = OP_LW;
        end
    end

    assign w_misaligned = ((w_op == OP_SW || w_op == OP_LW) && addr[1:0] != 2'b00) ||
                          ((w_op == OP_SH || w_op == OP_LH || w_op == OP_LHU) && addr[0]);

    // Byte-lane enables and lane-positioned store data for the incoming store.
    always_comb begin
        w_wen   = 4'b0000;
        w_wdata = 32'h0;
        case (w_op)
            OP_SW: begin
                w_wen   = 4'b1111;
                w_wdata = rt_data;
            end
            OP_SH: begin
                w_wen   = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{rt_data[15:0]}};
            end
            OP_SB: begin
                w_wen   = 4'b0001 << addr[1:0];
                w_wdata = {4{rt_data[7:0]}};
            end
            OP_SWL: begin
                case (addr[1:0])
                    2'd0: begin w_wen = 4'b0001; w_wdata = {24'h0, rt_data[31:24]}; end
                    2'd1: begin w_wen = 4'b0011; w_wdata = {16'h0, rt_data[31:16]}; end
                    2'd2: begin w_wen = 4'b0111; w_wdata = {8'h0, rt_data[31:8]};   end
                    default: begin w_wen = 4'b1111; w_wdata = rt_data;              end
                endcase
            end
            OP_SWR: begin
                case (addr[1:0])
                    2'd0: begin w_wen = 4'b1111; w_wdata = rt_data;                  end
                    2'd1: begin w_wen = 4'b1110; w_wdata = {rt_data[23:0], 8'h0};   end
                    2'd2: begin w_wen = 4'b1100; w_wdata = {rt_data[15:0], 16'h0};  end
                    default: begin w_wen = 4'b1000; w_wdata = {rt_data[7:0], 24'h0}; end
                endcase
            end
            default: ;
        endcase
    end

    // Align, extend or merge the returned word for the latched load kind.
    always_comb begin
        w_fmt  = 32'h0;
        w_half = r_a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_a)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        case (r_op)
            OP_LW:  w_fmt = mem_rdata;
            OP_LB:  w_fmt = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_fmt = {24'h0, w_byte};
            OP_LH:  w_fmt = {{16{w_half[15]}}, w_half};
            OP_LHU: w_fmt = {16'h0, w_half};
            OP_LWL: begin
                case (r_a)
                    2'd0:    w_fmt = {mem_rdata[7:0], r_rt[23:0]};
                    2'd1:    w_fmt = {mem_rdata[15:0], r_rt[15:0]};
                    2'd2:    w_fmt = {mem_rdata[23:0], r_rt[7:0]};
                    default: w_fmt = mem_rdata;
                endcase
            end
            OP_LWR: begin
                case (r_a)
                    2'd0:    w_fmt = mem_rdata;
                    2'd1:    w_fmt = {r_rt[31:24], mem_rdata[31:8]};
                    2'd2:    w_fmt = {r_rt[31:16], mem_rdata[31:16]};
                    default: w_fmt = {r_rt[31:8], mem_rdata[31:24]};
                endcase
            end
            default: w_fmt = 32'h0;
        endcase
    end

    assign w_timeout  = (r_cnt == CNT_LAST);
    assign w_is_store = (r_op == OP_SW || r_op == OP_SH || r_op == OP_SB ||
                         r_op == OP_SWL || r_op == OP_SWR);

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        // NOTE: sequential state uses non-blocking assignment so all flops update together.
        else         r_state <= w_next_state;
    end

    // Next-state logic; a grant or read-valid wins over a same-cycle timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid)
                    w_next_state = (w_op == OP_NONE || w_misaligned) ? S_DONE : S_REQ;
            end
            S_REQ: begin
                if (mem_gnt)        w_next_state = w_is_store ? S_DONE : S_WAIT_R;
                else if (w_timeout) w_next_state = S_DONE;
            end
            S_WAIT_R: begin
                if (mem_rvalid || w_timeout) w_next_state = S_DONE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operation latch, wait counter and completion result registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op        <= OP_NONE;
            r_a         <= 2'b00;
            r_rt        <= 32'h0;
            r_word      <= 30'h0;
            r_wen       <= 4'b0000;
            r_wdata     <= 32'h0;
            r_cnt       <= 16'h0;
            r_load_data <= 32'h0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op        <= w_op;
                        r_a         <= addr[1:0];
                        r_rt        <= rt_data;
                        r_word      <= addr[31:2];
                        r_wen       <= w_wen;
                        r_wdata     <= w_wdata;
                        r_cnt       <= 16'h0;
                        r_load_data <= 32'h0;
                        r_addr_err  <= w_misaligned;
                        r_bus_err   <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (mem_gnt)        r_cnt     <= 16'h0;
                    else if (w_timeout) r_bus_err <= 1'b1;
                    else                r_cnt     <= r_cnt + 16'd1;
                end
                S_WAIT_R: begin
                    if (mem_rvalid)     r_load_data <= w_fmt;
                    else if (w_timeout) r_bus_err   <= 1'b1;
                    else                r_cnt       <= r_cnt + 16'd1;
                end
                default: begin
                    r_load_data <= 32'h0;
                    r_addr_err  <= 1'b0;
                    r_bus_err   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign mem_req   = (r_state == S_REQ);
    assign out_valid = (r_state == S_DONE);
    assign mem_addr  = {r_word, 2'b00};
    assign mem_wen   = r_wen;
    assign mem_wdata = r_wdata;
    assign load_data = r_load_data;
    assign addr_err  = r_addr_err;
    assign bus_err   = r_bus_err;

endmodule
